sprite_loader: RTL

Writes the sprite sheet into `frameRAM` from a byte stream, filling the RAM that `color_mapper` reads for display. Each input byte carries two 4-bit palette IDs. The block unpacks them and drives `frameRAM`'s write port (`write_address`, `data_In`, `we`) in raster order, starting at address 0. It sits between the host/SD byte source and `frameRAM`, and raises `loaded` once the full 200×200 sheet is in place so gameplay can start.

---
 rtl/sprite_loader.sv | 92 +++++++++
 1 files changed

// File: rtl/sprite_loader.sv
// sprite_loader: unpacks a byte stream of 4-bit palette IDs into raster-order
// frameRAM writes and flags when the whole sprite sheet has been loaded.
module sprite_loader #(
    parameter int SS_WIDTH  = 200,
    parameter int SS_HEIGHT = 200,
    parameter int ADDR_W    = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] write_address,
    output logic [3:0]        data_In,
    output logic              we,
    output logic              busy,
    output logic              done,
    output logic              loaded
);
    localparam int TOTAL = SS_WIDTH * SS_HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [7:0]        byte_buf;
    logic              buf_valid;
    logic              nib;
    logic              accept;
    logic              last_write;

    // The next byte may land while the high nibble is written, except on the final pixel.
    assign in_ready      = (state == LOAD) && (!buf_valid || (nib && addr_cnt != LAST_ADDR));
    assign accept        = in_valid && in_ready;
    assign last_write    = buf_valid && (addr_cnt == LAST_ADDR);
    assign we            = buf_valid;
    assign write_address = addr_cnt;
    assign data_In       = nib ? byte_buf[7:4] : byte_buf[3:0];
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            byte_buf  <= '0;
            buf_valid <= 1'b0;
            nib       <= 1'b0;
            loaded    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        addr_cnt  <= '0;
                        buf_valid <= 1'b0;
                        nib       <= 1'b0;
                        loaded    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (buf_valid) begin
                        addr_cnt <= addr_cnt + ADDR_W'(1);
                        nib      <= ~nib;
                        if (last_write) begin
                            // An odd-sized sheet drops the unused high nibble here.
                            state     <= DONE;
                            buf_valid <= 1'b0;
                            nib       <= 1'b0;
                            loaded    <= 1'b1;
                        end else if (nib && !accept) begin
                            buf_valid <= 1'b0;
                        end
                    end
                    if (accept) begin
                        byte_buf  <= in_data;
                        buf_valid <= 1'b1;
                        nib       <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
